// File: rtl/signed_unary_pipe.sv
// Two-stage, back-pressurable pipeline that applies one signed unary operator per transaction.
// Define SIGNED_UNARY_SAT_EN to saturate NEG/ABS of the most negative value to MAX instead of wrapping.
module signed_unary_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_val,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [2:0] OP_NEG  = 3'd0;
    localparam logic [2:0] OP_ABS  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_LNOT = 3'd3;
    localparam logic [2:0] OP_RAND = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_RXOR = 3'd6;

    logic             s1_v_reg;
    logic [WIDTH-1:0] s1_val_reg;
    logic [2:0]       s1_op_reg;
    logic             s2_v_reg;
    logic [WIDTH-1:0] s2_data_reg;
    logic             s2_ovf_reg;
    logic             s2_zero_reg;
    logic [CNT_W-1:0] ovf_count_reg;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] min_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] neg_val;
    logic             is_min;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             zero_next;

    // MIN is a lone sign bit; MAX is its complement.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_min
            assign min_val[gi] = (gi == WIDTH - 1);
        end
    endgenerate

    assign max_val = ~min_val;

    assign s2_adv   = !s2_v_reg || out_ready;
    assign s1_adv   = !s1_v_reg || s2_adv;
    assign in_ready = s1_adv;

    assign neg_val = '0 - s1_val_reg;
    assign is_min  = (s1_val_reg == min_val);

    always_comb begin
        res_next = s1_val_reg;
        ovf_next = 1'b0;
        case (s1_op_reg)
            OP_NEG: begin
                res_next = neg_val;
                ovf_next = is_min;
            end
            OP_ABS: begin
                res_next = s1_val_reg[WIDTH-1] ? neg_val : s1_val_reg;
                ovf_next = is_min;
            end
            OP_NOT:  res_next = ~s1_val_reg;
            OP_LNOT: res_next = {{(WIDTH-1){1'b0}}, (s1_val_reg == '0)};
            OP_RAND: res_next = {{(WIDTH-1){1'b0}}, &s1_val_reg};
            OP_ROR:  res_next = {{(WIDTH-1){1'b0}}, |s1_val_reg};
            OP_RXOR: res_next = {{(WIDTH-1){1'b0}}, ^s1_val_reg};
            default: res_next = s1_val_reg;
        endcase
`ifdef SIGNED_UNARY_SAT_EN
        if (ovf_next) begin
            res_next = max_val;
        end
`else
        // Wrapping: two's-complement negation of MIN already yields MIN.
        res_next = res_next;
`endif
        zero_next = (res_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg      <= 1'b0;
            s1_val_reg    <= '0;
            s1_op_reg     <= '0;
            s2_v_reg      <= 1'b0;
            s2_data_reg   <= '0;
            s2_ovf_reg    <= 1'b0;
            s2_zero_reg   <= 1'b0;
            ovf_count_reg <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_reg <= in_valid;
                if (in_valid) begin
                    s1_val_reg <= in_val;
                    s1_op_reg  <= in_op;
                end
            end
            // Result registers only load with a real entry so stalled/idle outputs stay put.
            if (s2_adv) begin
                s2_v_reg <= s1_v_reg;
                if (s1_v_reg) begin
                    s2_data_reg <= res_next;
                    s2_ovf_reg  <= ovf_next;
                    s2_zero_reg <= zero_next;
                end
            end
            if (s2_v_reg && out_ready && s2_ovf_reg && (ovf_count_reg != '1)) begin
                ovf_count_reg <= ovf_count_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid = s2_v_reg;
    assign out_data  = s2_data_reg;
    assign out_ovf   = s2_ovf_reg;
    assign out_zero  = s2_zero_reg;
    assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_signed_unary_pipe.sv
// Directed scoreboard bench for signed_unary_pipe; a CNT_W=2 twin shares the stimulus for saturation.
module tb_signed_unary_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_val;
    logic [2:0] in_op;
    logic       out_ready;

    logic       in_ready, out_valid, out_ovf, out_zero;
    logic [7:0] out_data, ovf_count;
    logic       in_ready2, out_valid2, out_ovf2, out_zero2;
    logic [7:0] out_data2;
    logic [1:0] ovf_count2;

    int total = 0;
    int bad   = 0;

    logic [9:0] sb_q[$];
    int         exp8 = 0;
    int         exp2 = 0;
    logic       stalled = 1'b0;
    logic [9:0] held = '0;

    always #5 clk = ~clk;

    signed_unary_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_val(in_val), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_zero(out_zero), .ovf_count(ovf_count)
    );

    signed_unary_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_val(in_val), .in_op(in_op), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_ovf(out_ovf2), .out_zero(out_zero2), .ovf_count(ovf_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {data, ovf, zero}
    function automatic logic [9:0] model(input logic [7:0] x, input logic [2:0] op);
        logic [7:0] r;
        logic       o;
        o = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                if (x == 8'h80) begin
`ifdef SIGNED_UNARY_SAT_EN
                    r = 8'h7F;
`else
                    r = 8'h80;
`endif
                    o = 1'b1;
                end else if (op == 3'd0 || x[7]) begin
                    r = 8'(9'h100 - {1'b0, x});
                end else begin
                    r = x;
                end
            end
            3'd2:    r = x ^ 8'hFF;
            3'd3:    r = (x == 8'h00) ? 8'd1 : 8'd0;
            3'd4:    r = (x == 8'hFF) ? 8'd1 : 8'd0;
            3'd5:    r = (x != 8'h00) ? 8'd1 : 8'd0;
            3'd6:    r = {7'd0, x[0]^x[1]^x[2]^x[3]^x[4]^x[5]^x[6]^x[7]};
            default: r = x;
        endcase
        return {r, o, (r == 8'h00)};
    endfunction

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            sb_q.delete();
            exp8 = 0;
            exp2 = 0;
            stalled = 1'b0;
        end else begin
            check("ovf_count", 32'(ovf_count), 32'(exp8));
            check("ovf_count_w2", 32'(ovf_count2), 32'(exp2));
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_data, out_ovf, out_zero}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'({out_data, out_ovf, out_zero}), 32'h3FF000);
                end else begin
                    e = sb_q.pop_front();
                    $display("out data=%02h ovf=%0b zero=%0b exp=%02h/%0b/%0b",
                             out_data, out_ovf, out_zero, e[9:2], e[1], e[0]);
                    check("out_data", 32'(out_data), 32'(e[9:2]));
                    check("out_ovf", 32'(out_ovf), 32'(e[1]));
                    check("out_zero", 32'(out_zero), 32'(e[0]));
                    if (e[1]) begin
                        if (exp8 < 255) exp8++;
                        if (exp2 < 3) exp2++;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_data, out_ovf, out_zero};
        end
    end

    task automatic send(input logic [7:0] v, input logic [2:0] op);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_val   = v;
        in_op    = op;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(v, op));
                $display("in  val=%02h op=%0d", v, op);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        check("drain", 32'(done), 32'd1);
    endtask

    initial begin
        time t0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_val = '0;
        in_op = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: accepted at edge N, valid after edge N+1.
        send(8'h7F, 3'd0);
        in_valid = 1'b0;
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        drain();

        // Back-to-back stream, one accept per cycle.
        t0 = $time;
        send(8'h7F, 3'd0);
        send(8'h00, 3'd0);
        send(8'hFF, 3'd0);
        check("throughput", 32'($time - t0), 32'd30);
        drain();

        send(8'h80, 3'd0);
        send(8'h80, 3'd1);
        drain();
        check("ovf_count_two", 32'(ovf_count), 32'd2);

        send(8'hA5, 3'd2);
        send(8'hA5, 3'd3);
        send(8'hA5, 3'd4);
        send(8'hA5, 3'd5);
        send(8'hA5, 3'd6);
        send(8'h00, 3'd3);
        send(8'hFF, 3'd4);
        send(8'h00, 3'd5);
        send(8'h07, 3'd6);
        send(8'hF6, 3'd1);
        send(8'h05, 3'd1);
        send(8'h7F, 3'd1);
        send(8'h81, 3'd7);
        send(8'h00, 3'd0);
        drain();

        // Back-pressure: two accepts fill the pipe, then in_ready must fall.
        out_ready = 1'b0;
        send(8'h11, 3'd7);
        send(8'h22, 3'd2);
        in_val = 8'h33;
        in_op  = 3'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h33, 3'd7);
        send(8'h44, 3'd0);
        drain();

        // Reset with two entries in flight: neither may ever appear.
        out_ready = 1'b0;
        send(8'h80, 3'd0);
        send(8'h01, 3'd7);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Five overflow transfers: narrow counter saturates at 3.
        for (int k = 0; k < 5; k++) send(8'h80, 3'(k % 2));
        drain();
        check("sat_ovf_count_w2", 32'(ovf_count2), 32'd3);
        check("sat_ovf_count_w8", 32'(ovf_count), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
